// File: rtl/bp_me_trace_pkg.sv
// Shared types for the CCE trace buffer.
//   bp_me_trace_state_e     : capture FSM encoding (IDLE=0, CAPTURE=1, POST=2, DONE=3)
//   bp_me_trace_mode_e      : capture mode (wrap / stop-when-full / trigger)
//   declare_bp_me_trace_rec_S : macro declaring the packed record layout
//                               {timestamp, trig, fire mask, all headers}

`ifndef BP_ME_TRACE_PKG_SV
`define BP_ME_TRACE_PKG_SV

`define declare_bp_me_trace_rec_S(num_channels_mp, hdr_width_mp, timestamp_width_mp) \
    typedef struct packed { \
        logic [timestamp_width_mp-1:0]           timestamp; \
        logic                                    trig; \
        logic [num_channels_mp-1:0]              fire; \
        logic [num_channels_mp*hdr_width_mp-1:0] hdr; \
    } bp_me_trace_rec_s

package bp_me_trace_pkg;

    typedef enum logic [1:0] {
        e_trace_idle    = 2'd0,
        e_trace_capture = 2'd1,
        e_trace_post    = 2'd2,
        e_trace_done    = 2'd3
    } bp_me_trace_state_e;

    typedef enum logic [1:0] {
        e_trace_wrap      = 2'd0,
        e_trace_stop_full = 2'd1,
        e_trace_trigger   = 2'd2
    } bp_me_trace_mode_e;

endpackage

`endif

// File: rtl/bsg_mem_1r1w.sv
// Simple 1-write / 1-read register-array memory with asynchronous read.
//   w_clk_i   : write clock
//   w_v_i     : write enable
//   w_addr_i  : write address
//   w_data_i  : write data
//   r_addr_i  : read address
//   r_data_o  : read data, combinational from r_addr_i

module bsg_mem_1r1w #(
    parameter int width_p = 8,
    parameter int els_p   = 8,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_me_cce_trace_buffer.sv
// Capture buffer for CCE channel headers. Each cycle with at least one fired
// channel (valid & ack) during capture produces one record into a circular
// buffer; after capture ends the records are drained oldest-first.
//   clk_i, reset_n_i   : clock, async active-low reset
//   freeze_i           : hold all state (timestamp still runs)
//   ch_hdr_i/v_i/ack_i : monitored channels, fire = v & ack
//   mode_i, arm_i      : capture mode (latched on arm), start capture
//   stop_i, trigger_i  : force end, trigger event (trigger mode only)
//   post_count_i       : records kept after the trigger record
//   rd_v_o/data_o/yumi_i : drain port, valid only in DONE
//   state_o, count_o, wrapped_o : status

module bp_me_cce_trace_buffer
    import bp_me_trace_pkg::*;
#(
    parameter int num_channels_p    = 5,
    parameter int hdr_width_p       = 64,
    parameter int depth_p           = 256,
    parameter int timestamp_width_p = 32,
    localparam int lg_depth_lp  = $clog2(depth_p),
    localparam int rec_width_lp = timestamp_width_p + 1 + num_channels_p
                                  + num_channels_p*hdr_width_p
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  freeze_i,
    input  logic [num_channels_p*hdr_width_p-1:0] ch_hdr_i,
    input  logic [num_channels_p-1:0]             ch_v_i,
    input  logic [num_channels_p-1:0]             ch_ack_i,
    input  logic [1:0]                            mode_i,
    input  logic                                  arm_i,
    input  logic                                  stop_i,
    input  logic                                  trigger_i,
    input  logic [lg_depth_lp:0]                  post_count_i,
    output logic                                  rd_v_o,
    output logic [rec_width_lp-1:0]               rd_data_o,
    input  logic                                  rd_yumi_i,
    output logic [1:0]                            state_o,
    output logic [lg_depth_lp:0]                  count_o,
    output logic                                  wrapped_o
);

    `declare_bp_me_trace_rec_S(num_channels_p, hdr_width_p, timestamp_width_p);

    localparam logic [lg_depth_lp:0]   depth_lp    = (lg_depth_lp+1)'(depth_p);
    localparam logic [lg_depth_lp:0]   full_m1_lp  = (lg_depth_lp+1)'(depth_p-1);
    localparam logic [lg_depth_lp-1:0] post_max_lp = lg_depth_lp'(depth_p-1);

    bp_me_trace_state_e             state_q, state_d;
    bp_me_trace_mode_e              mode_q, mode_d;
    logic [lg_depth_lp-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [lg_depth_lp:0]           count_q, count_d;
    logic [lg_depth_lp-1:0]         post_q, post_d;
    logic                           wrapped_q, wrapped_d;
    logic [timestamp_width_p-1:0]   ts_q;

    logic [num_channels_p-1:0]      fire;
    logic                           wr_v, trig_acc, pop;
    logic [lg_depth_lp-1:0]         post_load;
    bp_me_trace_rec_s               wr_rec;

    assign fire     = ch_v_i & ch_ack_i;
    assign wr_v     = ((state_q == e_trace_capture) || (state_q == e_trace_post))
                      && !freeze_i && (|fire);
    // stop outranks trigger, so a simultaneous stop leaves the record untagged
    assign trig_acc = (state_q == e_trace_capture) && (mode_q == e_trace_trigger)
                      && trigger_i && !freeze_i && !stop_i;
    assign rd_v_o   = (state_q == e_trace_done) && (count_q != '0);
    assign pop      = rd_v_o && rd_yumi_i;
    assign post_load = (post_count_i > {1'b0, post_max_lp}) ? post_max_lp
                                                            : post_count_i[lg_depth_lp-1:0];

    always_comb begin
        wr_rec           = '0;
        wr_rec.timestamp = ts_q;
        wr_rec.trig      = trig_acc;
        wr_rec.fire      = fire;
        for (int k = 0; k < num_channels_p; k++) begin
            wr_rec.hdr[k*hdr_width_p +: hdr_width_p] =
                fire[k] ? ch_hdr_i[k*hdr_width_p +: hdr_width_p] : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        post_d    = post_q;
        wrapped_d = wrapped_q;

        if (!freeze_i) begin
            case (state_q)
                e_trace_capture, e_trace_post: begin
                    if (wr_v) begin
                        wr_ptr_d = wr_ptr_q + lg_depth_lp'(1);
                        if (count_q == depth_lp) begin
                            rd_ptr_d  = rd_ptr_q + lg_depth_lp'(1);
                            wrapped_d = 1'b1;
                        end else begin
                            count_d = count_q + (lg_depth_lp+1)'(1);
                        end
                    end
                    if (stop_i) begin
                        state_d = e_trace_done;
                    end else if (trig_acc) begin
                        post_d  = post_load;
                        state_d = (post_load == '0) ? e_trace_done : e_trace_post;
                    end else if ((state_q == e_trace_post) && wr_v) begin
                        post_d = post_q - lg_depth_lp'(1);
                        if (post_q == lg_depth_lp'(1)) begin
                            state_d = e_trace_done;
                        end
                    end else if ((mode_q == e_trace_stop_full) && wr_v
                                 && (count_q == full_m1_lp)) begin
                        state_d = e_trace_done;
                    end
                end
                default: begin
                    // IDLE and DONE: arm restarts capture and beats a same-cycle pop
                    if (arm_i) begin
                        state_d   = e_trace_capture;
                        mode_d    = (mode_i == 2'd3) ? e_trace_wrap
                                                     : bp_me_trace_mode_e'(mode_i);
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                        count_d   = '0;
                        post_d    = '0;
                        wrapped_d = 1'b0;
                    end else if (pop) begin
                        rd_ptr_d = rd_ptr_q + lg_depth_lp'(1);
                        count_d  = count_q - (lg_depth_lp+1)'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_trace_idle;
            mode_q    <= e_trace_wrap;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            ts_q      <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            wrapped_q <= wrapped_d;
            ts_q      <= ts_q + timestamp_width_p'(1);
        end
    end

    bsg_mem_1r1w #(
        .width_p (rec_width_lp),
        .els_p   (depth_p)
    ) mem (
        .w_clk_i  (clk_i),
        .w_v_i    (wr_v),
        .w_addr_i (wr_ptr_q),
        .w_data_i (wr_rec),
        .r_addr_i (rd_ptr_q),
        .r_data_o (rd_data_o)
    );

    assign state_o   = state_q;
    assign count_o   = count_q;
    assign wrapped_o = wrapped_q;

endmodule

// File: tb/tb_bp_me_cce_trace_buffer.sv
module tb_bp_me_cce_trace_buffer;

    localparam int NC = 2;
    localparam int HW = 8;
    localparam int D  = 8;
    localparam int TW = 16;
    localparam int LG = 3;
    localparam int RW = TW + 1 + NC + NC*HW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, freeze, arm, stop, trig, yumi;
    logic [NC*HW-1:0] hdr;
    logic [NC-1:0]   v, ack;
    logic [1:0]      mode;
    logic [LG:0]     post;
    logic            rd_v;
    logic [RW-1:0]   rd_data;
    logic [1:0]      state;
    logic [LG:0]     count;
    logic            wrapped;

    int n_cmp  = 0;
    int n_fail = 0;

    bp_me_cce_trace_buffer #(
        .num_channels_p    (NC),
        .hdr_width_p       (HW),
        .depth_p           (D),
        .timestamp_width_p (TW)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .freeze_i     (freeze),
        .ch_hdr_i     (hdr),
        .ch_v_i       (v),
        .ch_ack_i     (ack),
        .mode_i       (mode),
        .arm_i        (arm),
        .stop_i       (stop),
        .trigger_i    (trig),
        .post_count_i (post),
        .rd_v_o       (rd_v),
        .rd_data_o    (rd_data),
        .rd_yumi_i    (yumi),
        .state_o      (state),
        .count_o      (count),
        .wrapped_o    (wrapped)
    );

    typedef struct {
        logic        arm, stop, trig, freeze, yumi;
        logic [1:0]  mode, v, ack;
        logic [7:0]  h0, h1;
        logic [1:0]  e_state;
        logic [3:0]  e_count;
        logic        e_wrap, e_rdv, e_chk;
        logic [18:0] e_low;
    } vec_t;

    vec_t tv[10];

    function automatic vec_t mk(logic a, logic s, logic t, logic f, logic y,
                                logic [1:0] m, logic [1:0] vv, logic [1:0] aa,
                                logic [7:0] h0, logic [7:0] h1,
                                logic [1:0] es, logic [3:0] ec, logic ew,
                                logic er, logic ek, logic [18:0] el);
        vec_t r;
        r.arm = a; r.stop = s; r.trig = t; r.freeze = f; r.yumi = y;
        r.mode = m; r.v = vv; r.ack = aa; r.h0 = h0; r.h1 = h1;
        r.e_state = es; r.e_count = ec; r.e_wrap = ew; r.e_rdv = er;
        r.e_chk = ek; r.e_low = el;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        freeze = 0; arm = 0; stop = 0; trig = 0; yumi = 0;
        v = 0; ack = 0; hdr = 0; post = 0;
    endtask

    task automatic do_arm(input logic [1:0] m);
        mode = m; arm = 1; step(); arm = 0;
    endtask

    task automatic fire0(input logic [7:0] h);
        v = 2'b01; ack = 2'b01; hdr = {8'h00, h}; step();
        v = 0; ack = 0; hdr = 0;
    endtask

    task automatic drain(input string tag, input int n, input logic [7:0] first_h,
                         input int trig_idx);
        logic [TW-1:0] prev_ts;
        prev_ts = '0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_rdv%0d", tag, i), rd_v, 1);
            chk($sformatf("%s_hdr%0d", tag, i), rd_data[7:0], first_h + 8'(i));
            chk($sformatf("%s_mask%0d", tag, i), rd_data[17:16], 2'b01);
            chk($sformatf("%s_trig%0d", tag, i), rd_data[18], (i == trig_idx));
            if (i > 0)
                chk($sformatf("%s_tsinc%0d", tag, i), rd_data[RW-1 -: TW] > prev_ts, 1);
            prev_ts = rd_data[RW-1 -: TW];
            yumi = 1; step(); yumi = 0;
        end
        chk({tag, "_rdv_empty"}, rd_v, 0);
        chk({tag, "_count_empty"}, count, 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        mode = 0;
        rst_n = 0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_rdv", rd_v, 0);
        chk("rst_wrapped", wrapped, 0);
        step(); step();
        rst_n = 1;
        step();
        chk("idle_state", state, 0);

        // simultaneous fires, ack gating, freeze, stop+trigger, arm vs pop
        tv[0] = mk(1,0,0,0,0, 2'd2, 2'b00,2'b00, 8'h00,8'h00, 2'd1,4'd0,0,0,0, 19'h0);
        tv[1] = mk(0,0,0,0,0, 2'd2, 2'b11,2'b11, 8'hAA,8'h55, 2'd1,4'd1,0,0,0, 19'h0);
        tv[2] = mk(0,0,0,0,0, 2'd2, 2'b01,2'b00, 8'h77,8'h00, 2'd1,4'd1,0,0,0, 19'h0);
        tv[3] = mk(0,0,0,1,0, 2'd2, 2'b01,2'b01, 8'h66,8'h00, 2'd1,4'd1,0,0,0, 19'h0);
        tv[4] = mk(0,0,1,1,0, 2'd2, 2'b01,2'b01, 8'h65,8'h00, 2'd1,4'd1,0,0,0, 19'h0);
        tv[5] = mk(0,1,1,0,0, 2'd2, 2'b01,2'b01, 8'h33,8'h00, 2'd3,4'd2,0,1,1,
                   {1'b0, 2'b11, 8'h55, 8'hAA});
        tv[6] = mk(0,0,0,0,1, 2'd2, 2'b00,2'b00, 8'h00,8'h00, 2'd3,4'd1,0,1,1,
                   {1'b0, 2'b01, 8'h00, 8'h33});
        tv[7] = mk(1,0,0,0,1, 2'd1, 2'b00,2'b00, 8'h00,8'h00, 2'd1,4'd0,0,0,0, 19'h0);
        tv[8] = mk(0,1,0,0,0, 2'd1, 2'b00,2'b00, 8'h00,8'h00, 2'd3,4'd0,0,0,0, 19'h0);
        tv[9] = mk(0,0,0,0,1, 2'd1, 2'b00,2'b00, 8'h00,8'h00, 2'd3,4'd0,0,0,0, 19'h0);

        for (int i = 0; i < 10; i++) begin
            arm = tv[i].arm; stop = tv[i].stop; trig = tv[i].trig;
            freeze = tv[i].freeze; yumi = tv[i].yumi; mode = tv[i].mode;
            v = tv[i].v; ack = tv[i].ack; hdr = {tv[i].h1, tv[i].h0}; post = 4'd3;
            step();
            clr_in();
            chk($sformatf("vec%0d_state", i), state, tv[i].e_state);
            chk($sformatf("vec%0d_count", i), count, tv[i].e_count);
            chk($sformatf("vec%0d_wrapped", i), wrapped, tv[i].e_wrap);
            chk($sformatf("vec%0d_rdv", i), rd_v, tv[i].e_rdv);
            if (tv[i].e_chk)
                chk($sformatf("vec%0d_data", i), rd_data[18:0], tv[i].e_low);
        end

        // mode 0: wrap
        do_arm(2'd0);
        for (int i = 1; i <= 10; i++) fire0(8'(i));
        chk("m0_state_cap", state, 1);
        stop = 1; step(); stop = 0;
        chk("m0_state", state, 3);
        chk("m0_count", count, 8);
        chk("m0_wrapped", wrapped, 1);
        drain("m0", 8, 8'h03, -1);

        // mode 1: stop when full
        do_arm(2'd1);
        chk("m1_wrap_clr", wrapped, 0);
        for (int i = 0; i < 12; i++) begin
            fire0(8'h20 + 8'(i));
            if (i == 6) chk("m1_state_7th", state, 1);
            if (i == 7) begin
                chk("m1_state_8th", state, 3);
                chk("m1_count_8th", count, 8);
            end
        end
        chk("m1_count", count, 8);
        chk("m1_wrapped", wrapped, 0);
        drain("m1", 8, 8'h20, -1);

        // mode 2: trigger with two post records
        do_arm(2'd2);
        fire0(8'h10);
        fire0(8'h11);
        trig = 1; post = 4'd2; fire0(8'h12); trig = 0; post = 0;
        chk("m2_state_trig", state, 2);
        fire0(8'h13);
        chk("m2_state_post1", state, 2);
        fire0(8'h14);
        chk("m2_state_done", state, 3);
        chk("m2_count", count, 5);
        fire0(8'h15);
        chk("m2_count_after", count, 5);
        drain("m2", 5, 8'h10, 2);

        // reset in the middle of a capture
        do_arm(2'd0);
        fire0(8'h41); fire0(8'h42); fire0(8'h43);
        chk("mr_count_pre", count, 3);
        #2;
        rst_n = 0;
        #1;
        chk("mr_state", state, 0);
        chk("mr_count", count, 0);
        chk("mr_rdv", rd_v, 0);
        chk("mr_wrapped", wrapped, 0);
        step();
        rst_n = 1;
        step();
        chk("mr_state_after", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
